fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one 9-bit FIFO write port among NREQ requesters.
- Grants one requester at a time for a burst of up to BURST beats.
- Stalls on FIFO full and rotates priority after each burst.
- Sits directly in front of the fifo block's write side; the FIFO read side is untouched.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 9, data width per requester (matches FIFO din)
BURST, 4, max accepted beats per grant (1..15)

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester write request; bit i = requester i
data_in  input  NREQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
full  input  1  FIFO full flag
gnt  output  NREQ  registered one-hot grant; all-zero when idle
wr_en  output  1  FIFO write strobe (combinational)
wr_data  output  WIDTH  FIFO write data (combinational)
busy  output  1  registered; 1 while in GRANT state

Behaviour:
- Reset is synchronous, active-high, sampled on posedge clock. Reset values:
  - state=IDLE, gnt=0, busy=0, ptr=0, beat count=0.
  - wr_en=0 and wr_data=0, since both are driven from state=IDLE.
- Reset mid-burst aborts the burst immediately; no wr_en in the reset cycle or the following cycle.
- FSM, two states:
  - IDLE:
    - gnt=0, wr_en=0, wr_data=0.
    - If |req: select owner = first index i with req[i]=1, searching ptr, ptr+1, ... mod NREQ.
    - On the next edge: gnt<=onehot(owner), busy<=1, count<=0, go to GRANT.
    - Arbitration costs exactly one IDLE cycle. `full` is ignored in IDLE.
  - GRANT:
    - Beat accepted in a cycle iff req[owner]=1 and full=0.
    - When accepted: wr_en=1 and wr_data=data_in slice of owner, same cycle (combinational); count increments.
    - full=1 with req[owner]=1: stall. wr_en=0, count held, remain in GRANT, no timeout.
    - req[owner]=0: end burst this cycle with no write.
    - Accepted beat with count=BURST-1: end burst after that write.
    - On burst end, at the next edge: gnt<=0, busy<=0, ptr<=(owner+1) mod NREQ, go to IDLE.
- Constraints:
  - wr_en never asserts while full=1.
  - gnt has at most one bit set.
  - Requests from non-owners are ignored during GRANT.
  - Beats always come from the owner, never from another requester.
- Fairness: with all requesters continuously active and full=0, each requester gets BURST beats per NREQ*(BURST+1) cycles.
- Simultaneous full deassert and req drop in the same cycle: the req drop wins; no write, burst ends.

Optional Feature:
- Macro: FIFO_ARB_PARITY_EN.
- Defined:
  - wr_data[WIDTH-1] = even parity (XOR) of the owner's data[WIDTH-2:0].
  - The requester's own top bit is discarded.
  - wr_data[WIDTH-2:0] pass through unchanged.
- Undefined: wr_data = owner's full WIDTH-bit slice, unmodified.

Test Plan:
1. Reset:
   - Stimulus: reset=1 for 3 cycles with req=4'b1111.
   - Required: gnt=0, busy=0, wr_en=0 throughout.
   - Required: after reset falls, first grant is gnt=4'b0001 after one IDLE cycle.
2. Single requester:
   - Stimulus: req=4'b0100 held, data_in[2]=9'h1A5, full=0.
   - Required: gnt=4'b0100.
   - Required: 4 consecutive wr_en pulses, wr_data=9'h1A5.
   - Required: 1 IDLE cycle (gnt=0), then regrant to requester 2.
3. Round-robin:
   - Stimulus: req=4'b1111 held, full=0.
   - Required: grant order 0,1,2,3,0.
   - Required: 4 beats each, 5-cycle period per requester, 16 writes in 20 cycles.
4. Full stall:
   - Stimulus: during requester 1's burst, after 2 beats, full=1 for 3 cycles.
   - Required: wr_en=0 for those 3 cycles and gnt held at 4'b0010.
   - Required: 2 remaining beats after full falls, 4 writes total.
5. Early release:
   - Stimulus: requester 3 drops req after 2 beats while req[0] is active.
   - Required: gnt=0 for one cycle, then gnt=4'b0001 (ptr wrapped 3->0).
6. Parity build:
   - Stimulus: FIFO_ARB_PARITY_EN defined, data_in[0]=9'h007.
   - Required: wr_data=9'h107.
   - Required: with the macro undefined, wr_data=9'h007.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter that shares one FIFO write port among NREQ
//            requesters. The arbiter grants one requester at a time for a
//            burst of up to BURST beats. It stalls while the FIFO is full and
//            rotates priority after every burst.
// Ports    : clock    - system clock, all state changes on posedge
//            reset    - synchronous, active-high
//            req      - per-requester write request (bit i = requester i)
//            data_in  - requester i data on [i*WIDTH +: WIDTH]
//            full     - FIFO full flag
//            gnt      - registered one-hot grant, zero when idle
//            wr_en    - FIFO write strobe (combinational)
//            wr_data  - FIFO write data (combinational, zero when no write)
//            busy     - registered, high while a grant is held
// Options  : FIFO_ARB_PARITY_EN - when defined, wr_data[WIDTH-1] carries the
//            even (XOR) parity of the owner's data[WIDTH-2:0]. The
//            requester's own top bit is discarded.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 9,
  parameter int BURST = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  input  logic                  full,
  output logic [NREQ-1:0]       gnt,
  output logic                  wr_en,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  busy
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = 4;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PTRW-1:0]  r_ptr, w_ptr_nxt;
  logic [PTRW-1:0]  r_owner, w_owner_nxt;
  logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic             r_busy, w_busy_nxt;

  logic [PTRW-1:0]  w_sel;
  logic             w_sel_vld;
  logic [WIDTH-1:0] w_owner_data;
  logic [WIDTH-1:0] w_fmt_data;
  logic             w_own_req;
  logic             w_accept;
  logic             w_last;

  // Rotating priority search. The loop runs from the farthest distance down
  // to the nearest so that the requester closest to r_ptr wins.
  always_comb begin : p_search
    int w_idx;
    w_sel     = '0;
    w_sel_vld = 1'b0;
    w_idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      if (req[w_idx[PTRW-1:0]]) begin
        w_sel     = w_idx[PTRW-1:0];
        w_sel_vld = 1'b1;
      end
    end
  end

  // Owner's request bit and data slice
  always_comb begin
    w_owner_data = '0;
    w_own_req    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == PTRW'(i)) begin
        w_owner_data = data_in[i*WIDTH +: WIDTH];
        w_own_req    = req[i];
      end
    end
  end

`ifdef FIFO_ARB_PARITY_EN
  assign w_fmt_data = {^w_owner_data[WIDTH-2:0], w_owner_data[WIDTH-2:0]};
`else
  assign w_fmt_data = w_owner_data;
`endif

  // Next-state and output logic
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_busy_nxt  = r_busy;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;

    case (r_state)
      S_IDLE: begin
        w_gnt_nxt  = '0;
        w_busy_nxt = 1'b0;
        if (w_sel_vld) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_sel;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_gnt_nxt   = NREQ'(1) << w_sel;
        end
      end

      S_GRANT: begin
        // Reset held during a burst suppresses the write in that same cycle
        w_accept = w_own_req && !full && !reset;
        w_last   = w_accept && (r_cnt == CNTW'(BURST - 1));
        if (w_accept) begin
          wr_en     = 1'b1;
          wr_data   = w_fmt_data;
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
        // Dropping the request ends the burst even if full falls this cycle
        if (!w_own_req || w_last) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          if (r_owner == PTRW'(NREQ - 1)) begin
            w_ptr_nxt = '0;
          end else begin
            w_ptr_nxt = r_owner + PTRW'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign busy = r_busy;

endmodule
`default_nettype wire
